// File: rtl/sirv_pwm8_icb_arb.sv
`default_nettype none
// ============================================================================
// Module   : sirv_pwm8_icb_arb
// Function : Two-requester ICB arbiter (round-robin, stall hold, in-order
//            response routing) in front of the pwm8 register slave port.
//            Optional command locking is enabled by SIRV_PWM8_ARB_LOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module sirv_pwm8_icb_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                             clock,
    input  logic                             reset,

    input  logic                             m0_icb_cmd_valid,
    output logic                             m0_icb_cmd_ready,
    input  logic [AW-1:0]                    m0_icb_cmd_addr,
    input  logic                             m0_icb_cmd_read,
    input  logic [DW-1:0]                    m0_icb_cmd_wdata,
    output logic                             m0_icb_rsp_valid,
    input  logic                             m0_icb_rsp_ready,
    output logic [DW-1:0]                    m0_icb_rsp_rdata,

    input  logic                             m1_icb_cmd_valid,
    output logic                             m1_icb_cmd_ready,
    input  logic [AW-1:0]                    m1_icb_cmd_addr,
    input  logic                             m1_icb_cmd_read,
    input  logic [DW-1:0]                    m1_icb_cmd_wdata,
    output logic                             m1_icb_rsp_valid,
    input  logic                             m1_icb_rsp_ready,
    output logic [DW-1:0]                    m1_icb_rsp_rdata,

`ifdef SIRV_PWM8_ARB_LOCK_EN
    input  logic                             m0_icb_cmd_lock,
    input  logic                             m1_icb_cmd_lock,
`endif

    output logic                             o_icb_cmd_valid,
    input  logic                             o_icb_cmd_ready,
    output logic [AW-1:0]                    o_icb_cmd_addr,
    output logic                             o_icb_cmd_read,
    output logic [DW-1:0]                    o_icb_cmd_wdata,
    input  logic                             o_icb_rsp_valid,
    output logic                             o_icb_rsp_ready,
    input  logic [DW-1:0]                    o_icb_rsp_rdata,

    output logic [$clog2(OUTS_DEPTH+1)-1:0]  outs_cnt,
    output logic                             rsp_err
);

    localparam int CW = $clog2(OUTS_DEPTH + 1);
    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(OUTS_DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(OUTS_DEPTH - 1);

    localparam logic [0:0] ST_OPEN = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic                  hold_id;
    logic                  rr_ptr;
    logic                  active;
    logic                  en;
    logic                  grant_id;
    logic                  sel_valid;
    logic                  full;
    logic                  empty;
    logic                  cmd_hsk;
    logic                  rr_upd;
    logic                  push;
    logic                  pop;
    logic                  drain;
    logic                  head_id;
    logic [OUTS_DEPTH-1:0] fifo_mem;
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;

    // Outputs stay quiet during reset and for one cycle after it.
    always_ff @(posedge clock) begin
        if (reset) active <= 1'b0;
        else       active <= 1'b1;
    end

    assign en    = active & ~reset;
    assign full  = (outs_cnt == DEPTH_CNT);
    assign empty = (outs_cnt == '0);

`ifdef SIRV_PWM8_ARB_LOCK_EN
    logic locked;
    logic lock_owner;
    logic cmd_lock;

    assign cmd_lock = grant_id ? m1_icb_cmd_lock : m0_icb_cmd_lock;

    always_ff @(posedge clock) begin
        if (reset) begin
            locked     <= 1'b0;
            lock_owner <= 1'b0;
        end else if (cmd_hsk) begin
            locked     <= cmd_lock;
            lock_owner <= grant_id;
        end
    end

    // The releasing (lock=0) handshake is the one that advances round-robin.
    assign rr_upd = cmd_hsk & ~cmd_lock;
`else
    assign rr_upd = cmd_hsk;
`endif

    // ---------------- grant FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_OPEN;
            hold_id <= 1'b0;
            rr_ptr  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_OPEN && state_nxt == ST_HOLD)
                hold_id <= grant_id;
            if (rr_upd)
                rr_ptr <= ~grant_id;
        end
    end

    // ---------------- grant FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_OPEN: if (o_icb_cmd_valid && !o_icb_cmd_ready) state_nxt = ST_HOLD;
            ST_HOLD: if (cmd_hsk)                             state_nxt = ST_OPEN;
            default:                                          state_nxt = ST_OPEN;
        endcase
    end

    // ---------------- grant FSM: outputs (grant selection) ----------------
    always_comb begin
        grant_id = rr_ptr;
        if (state == ST_HOLD)
            grant_id = hold_id;
`ifdef SIRV_PWM8_ARB_LOCK_EN
        else if (locked)
            grant_id = lock_owner;
`endif
        else if (m0_icb_cmd_valid && m1_icb_cmd_valid)
            grant_id = rr_ptr;
        else if (m0_icb_cmd_valid)
            grant_id = 1'b0;
        else if (m1_icb_cmd_valid)
            grant_id = 1'b1;
    end

    assign sel_valid = grant_id ? m1_icb_cmd_valid : m0_icb_cmd_valid;

    assign o_icb_cmd_valid  = en & sel_valid & ~full;
    assign o_icb_cmd_addr   = grant_id ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign o_icb_cmd_read   = grant_id ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign o_icb_cmd_wdata  = grant_id ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;

    assign m0_icb_cmd_ready = en & ~full & o_icb_cmd_ready & ~grant_id;
    assign m1_icb_cmd_ready = en & ~full & o_icb_cmd_ready &  grant_id;

    assign cmd_hsk = o_icb_cmd_valid & o_icb_cmd_ready;

    // ---------------- response routing ----------------
    assign head_id = fifo_mem[rptr];

    always_comb begin
        m0_icb_rsp_valid = 1'b0;
        m1_icb_rsp_valid = 1'b0;
        o_icb_rsp_ready  = 1'b0;
        if (en) begin
            if (empty) begin
                o_icb_rsp_ready = 1'b1;
            end else if (head_id) begin
                m1_icb_rsp_valid = o_icb_rsp_valid;
                o_icb_rsp_ready  = m1_icb_rsp_ready;
            end else begin
                m0_icb_rsp_valid = o_icb_rsp_valid;
                o_icb_rsp_ready  = m0_icb_rsp_ready;
            end
        end
    end

    assign m0_icb_rsp_rdata = o_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = o_icb_rsp_rdata;

    assign push  = cmd_hsk;
    assign pop   = o_icb_rsp_valid & o_icb_rsp_ready & ~empty;
    assign drain = o_icb_rsp_valid & o_icb_rsp_ready &  empty;

    // ---------------- outstanding-id FIFO ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            outs_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= grant_id;
                wptr           <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
            end
            if (pop)
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
            case ({push, pop})
                2'b10:   outs_cnt <= outs_cnt + CW'(1);
                2'b01:   outs_cnt <= outs_cnt - CW'(1);
                default: outs_cnt <= outs_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)      rsp_err <= 1'b0;
        else if (drain) rsp_err <= 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_sirv_pwm8_icb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sirv_pwm8_icb_arb
// Function : Directed self-checking bench for sirv_pwm8_icb_arb.
// Revision : 1.0  initial release
// ============================================================================
module tb_sirv_pwm8_icb_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OUTS_DEPTH = 2;
    localparam int CW = $clog2(OUTS_DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [AW-1:0] m0_icb_cmd_addr;
    logic [DW-1:0] m0_icb_cmd_wdata, m0_icb_rsp_rdata;
    logic          m0_icb_rsp_valid, m0_icb_rsp_ready;
    logic          m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [AW-1:0] m1_icb_cmd_addr;
    logic [DW-1:0] m1_icb_cmd_wdata, m1_icb_rsp_rdata;
    logic          m1_icb_rsp_valid, m1_icb_rsp_ready;
    logic          m0_icb_cmd_lock, m1_icb_cmd_lock;
    logic          o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
    logic [AW-1:0] o_icb_cmd_addr;
    logic [DW-1:0] o_icb_cmd_wdata, o_icb_rsp_rdata;
    logic          o_icb_rsp_valid, o_icb_rsp_ready;
    logic [CW-1:0] outs_cnt;
    logic          rsp_err;

    int errs   = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sirv_pwm8_icb_arb #(.AW(AW), .DW(DW), .OUTS_DEPTH(OUTS_DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .m0_icb_cmd_valid (m0_icb_cmd_valid),
        .m0_icb_cmd_ready (m0_icb_cmd_ready),
        .m0_icb_cmd_addr  (m0_icb_cmd_addr),
        .m0_icb_cmd_read  (m0_icb_cmd_read),
        .m0_icb_cmd_wdata (m0_icb_cmd_wdata),
        .m0_icb_rsp_valid (m0_icb_rsp_valid),
        .m0_icb_rsp_ready (m0_icb_rsp_ready),
        .m0_icb_rsp_rdata (m0_icb_rsp_rdata),
        .m1_icb_cmd_valid (m1_icb_cmd_valid),
        .m1_icb_cmd_ready (m1_icb_cmd_ready),
        .m1_icb_cmd_addr  (m1_icb_cmd_addr),
        .m1_icb_cmd_read  (m1_icb_cmd_read),
        .m1_icb_cmd_wdata (m1_icb_cmd_wdata),
        .m1_icb_rsp_valid (m1_icb_rsp_valid),
        .m1_icb_rsp_ready (m1_icb_rsp_ready),
        .m1_icb_rsp_rdata (m1_icb_rsp_rdata),
`ifdef SIRV_PWM8_ARB_LOCK_EN
        .m0_icb_cmd_lock  (m0_icb_cmd_lock),
        .m1_icb_cmd_lock  (m1_icb_cmd_lock),
`endif
        .o_icb_cmd_valid  (o_icb_cmd_valid),
        .o_icb_cmd_ready  (o_icb_cmd_ready),
        .o_icb_cmd_addr   (o_icb_cmd_addr),
        .o_icb_cmd_read   (o_icb_cmd_read),
        .o_icb_cmd_wdata  (o_icb_cmd_wdata),
        .o_icb_rsp_valid  (o_icb_rsp_valid),
        .o_icb_rsp_ready  (o_icb_rsp_ready),
        .o_icb_rsp_rdata  (o_icb_rsp_rdata),
        .outs_cnt         (outs_cnt),
        .rsp_err          (rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step;
        @(negedge clock);
    endtask

    initial begin
        m0_icb_cmd_valid = 0; m0_icb_cmd_addr = '0; m0_icb_cmd_read = 0; m0_icb_cmd_wdata = '0;
        m1_icb_cmd_valid = 0; m1_icb_cmd_addr = '0; m1_icb_cmd_read = 0; m1_icb_cmd_wdata = '0;
        m0_icb_rsp_ready = 1; m1_icb_rsp_ready = 1;
        m0_icb_cmd_lock  = 0; m1_icb_cmd_lock  = 0;
        o_icb_cmd_ready  = 1; o_icb_rsp_valid  = 0; o_icb_rsp_rdata = '0;

        // ---- reset state ----
        step; step;
        m0_icb_cmd_valid = 1;
        #1;
        check("rst_cmd_valid", o_icb_cmd_valid, 0);
        check("rst_m0_ready", m0_icb_cmd_ready, 0);
        check("rst_outs_cnt", outs_cnt, 0);
        check("rst_rsp_err", rsp_err, 0);
        step; reset = 0; #1;
        check("post_rst_cmd_valid", o_icb_cmd_valid, 0);
        check("post_rst_m0_ready", m0_icb_cmd_ready, 0);

        // ---- both valid, immediate responses: strict alternation ----
        for (int i = 0; i < 5; i++) begin
            step;
            m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h100 + 32'(i); m0_icb_cmd_read = 1;
            m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h200 + 32'(i); m1_icb_cmd_read = 1;
            o_icb_rsp_valid  = (i > 0); o_icb_rsp_rdata = 32'h1000 + 32'(i);
            #1;
            check("alt_addr", o_icb_cmd_addr, (i % 2 == 0) ? 32'h100 + 32'(i) : 32'h200 + 32'(i));
            check("alt_m0_ready", m0_icb_cmd_ready, (i % 2 == 0));
            check("alt_m1_ready", m1_icb_cmd_ready, (i % 2 == 1));
            check("alt_outs_cnt", outs_cnt, (i > 0));
            if (i > 0) begin
                check("alt_m0_rsp_valid", m0_icb_rsp_valid, ((i - 1) % 2 == 0));
                check("alt_m1_rsp_valid", m1_icb_rsp_valid, ((i - 1) % 2 == 1));
                check("alt_rdata", (((i - 1) % 2 == 0) ? m0_icb_rsp_rdata : m1_icb_rsp_rdata),
                      32'h1000 + 32'(i));
            end
        end
        step;
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;
        o_icb_rsp_rdata = 32'h1005;
        #1;
        check("drain_m0_rsp_valid", m0_icb_rsp_valid, 1);
        check("drain_rdata", m0_icb_rsp_rdata, 32'h1005);

        // ---- stall hold: m0 held 3 cycles even though rr_ptr now favours m1 ----
        step;
        o_icb_rsp_valid = 0; o_icb_cmd_ready = 0;
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h1002_4000; m0_icb_cmd_read = 1;
        #1;
        check("stall_valid", o_icb_cmd_valid, 1);
        check("stall_addr0", o_icb_cmd_addr, 32'h1002_4000);
        check("stall_outs_cnt", outs_cnt, 0);
        for (int j = 1; j < 3; j++) begin
            step;
            m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h200; m1_icb_cmd_read = 0;
            #1;
            check("stall_addr", o_icb_cmd_addr, 32'h1002_4000);
            check("stall_read", o_icb_cmd_read, 1);
            check("stall_m1_ready", m1_icb_cmd_ready, 0);
        end
        step; o_icb_cmd_ready = 1; #1;
        check("stall_hsk_m0_ready", m0_icb_cmd_ready, 1);
        check("stall_hsk_addr", o_icb_cmd_addr, 32'h1002_4000);
        step; m0_icb_cmd_valid = 0; #1;
        check("after_stall_addr", o_icb_cmd_addr, 32'h200);
        check("after_stall_m1_ready", m1_icb_cmd_ready, 1);

        // ---- FIFO full with responses withheld ----
        step;
        m1_icb_cmd_valid = 0;
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h300; m0_icb_cmd_read = 0;
        m0_icb_cmd_wdata = 32'hDEAD_BEEF;
        #1;
        check("full_outs_cnt", outs_cnt, 2);
        check("full_m0_ready", m0_icb_cmd_ready, 0);
        check("full_cmd_valid", o_icb_cmd_valid, 0);
        step; o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'hA5; #1;
        check("rspA5_m0_valid", m0_icb_rsp_valid, 1);
        check("rspA5_m1_valid", m1_icb_rsp_valid, 0);
        check("rspA5_rdata", m0_icb_rsp_rdata, 32'hA5);
        check("full_pop_no_push", m0_icb_cmd_ready, 0);
        step; o_icb_rsp_rdata = 32'h5A; #1;
        check("rsp5A_m1_valid", m1_icb_rsp_valid, 1);
        check("rsp5A_m0_valid", m0_icb_rsp_valid, 0);
        check("rsp5A_rdata", m1_icb_rsp_rdata, 32'h5A);
        check("third_m0_ready", m0_icb_cmd_ready, 1);
        check("third_addr", o_icb_cmd_addr, 32'h300);
        check("third_wdata", o_icb_cmd_wdata, 32'hDEAD_BEEF);
        check("third_outs_cnt", outs_cnt, 1);

        // ---- m1 response back-pressure at FIFO head ----
        step;
        m0_icb_cmd_valid = 0;
        m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h204;
        o_icb_rsp_rdata = 32'h77;
        #1;
        check("bp_setup_m0_rsp", m0_icb_rsp_valid, 1);
        check("bp_setup_m1_ready", m1_icb_cmd_ready, 1);
        for (int k = 0; k < 4; k++) begin
            step;
            m1_icb_cmd_valid = 0; m1_icb_rsp_ready = 0; o_icb_rsp_rdata = 32'h99;
            #1;
            check("bp_o_rsp_ready", o_icb_rsp_ready, 0);
            check("bp_m0_rsp_valid", m0_icb_rsp_valid, 0);
            check("bp_m1_rsp_valid", m1_icb_rsp_valid, 1);
            check("bp_outs_cnt", outs_cnt, 1);
        end
        step; m1_icb_rsp_ready = 1; #1;
        check("bp_release_ready", o_icb_rsp_ready, 1);
        check("bp_release_rdata", m1_icb_rsp_rdata, 32'h99);

        // ---- unexpected response with FIFO empty ----
        step; #1;
        check("orphan_outs_cnt", outs_cnt, 0);
        check("orphan_rsp_ready", o_icb_rsp_ready, 1);
        check("orphan_m0_valid", m0_icb_rsp_valid, 0);
        check("orphan_m1_valid", m1_icb_rsp_valid, 0);
        check("orphan_err_before", rsp_err, 0);
        step; o_icb_rsp_valid = 0; #1;
        check("orphan_err_set", rsp_err, 1);
        step;
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h104; m0_icb_cmd_read = 1;
        #1;
        check("orphan_err_sticky", rsp_err, 1);
        check("pre_reset_m0_ready", m0_icb_cmd_ready, 1);

        // ---- reset mid-transaction ----
        step;
        m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 1; reset = 1;
        #1;
        check("midrst_outs_cnt", outs_cnt, 1);
        check("midrst_cmd_valid", o_icb_cmd_valid, 0);
        check("midrst_m1_ready", m1_icb_cmd_ready, 0);
        step; reset = 0; m1_icb_cmd_valid = 0; #1;
        check("midrst_err_clr", rsp_err, 0);
        check("midrst_cnt_clr", outs_cnt, 0);
        step; o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'h55; #1;
        check("inflight_rsp_ready", o_icb_rsp_ready, 1);
        check("inflight_m0_valid", m0_icb_rsp_valid, 0);
        check("inflight_m1_valid", m1_icb_rsp_valid, 0);
        step; o_icb_rsp_valid = 0; #1;
        check("inflight_err", rsp_err, 1);

`ifdef SIRV_PWM8_ARB_LOCK_EN
        // ---- locked burst from m1 blocks m0 until lock=0 handshake ----
        step;
        m1_icb_cmd_valid = 1; m1_icb_cmd_lock = 1; m1_icb_cmd_addr = 32'h210;
        #1;
        check("lock1_m1_ready", m1_icb_cmd_ready, 1);
        step;
        m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h110;
        o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'h61;
        #1;
        check("lock2_m0_ready", m0_icb_cmd_ready, 0);
        check("lock2_m1_ready", m1_icb_cmd_ready, 1);
        check("lock2_m1_rsp", m1_icb_rsp_valid, 1);
        step; m1_icb_cmd_lock = 0; #1;
        check("lock3_m0_ready", m0_icb_cmd_ready, 0);
        check("lock3_m1_ready", m1_icb_cmd_ready, 1);
        step; m1_icb_cmd_valid = 0; #1;
        check("unlock_m0_ready", m0_icb_cmd_ready, 1);
        check("unlock_addr", o_icb_cmd_addr, 32'h110);
        step; m0_icb_cmd_valid = 0; o_icb_rsp_valid = 0;
`endif

        step; step;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
